// File: rtl/huffman_pkg.sv
// Shared types for the Huffman encoder: FSM states and the code-table entry layout.
// Table entries always hold a 16-bit code field, so any MAXLEN from 1 to 16 fits.
package huffman_pkg;
    localparam int MAXLEN_DEF = 16;
    localparam int CODE_W     = 16;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [4:0]        len;
        logic [CODE_W-1:0] code;
    } tbl_entry_t;
endpackage

// File: rtl/huffman_code_table.sv
// 256-entry symbol-to-code register file: one synchronous write port and one
// combinational read port. The whole table is cleared on reset, so every symbol starts unmapped.
module huffman_code_table
    import huffman_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] waddr,
    input  tbl_entry_t wdata,
    input  logic [7:0] raddr,
    output tbl_entry_t rdata
);

    tbl_entry_t mem [256];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/huffman_encoder.sv
// Streaming Huffman encoder: looks up each symbol's code and packs the codes MSB-first
// into bytes. A final flush emits the last partial byte, zero-padded.
module huffman_encoder
    import huffman_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int ACCW   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    input  logic [7:0]        sym_data,
    input  logic              sym_last,
    output logic              sym_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    input  logic              out_ready,
    input  logic              tbl_we,
    input  logic [7:0]        tbl_addr,
    input  logic [MAXLEN-1:0] tbl_code,
    input  logic [4:0]        tbl_len,
    output logic              busy,
    output logic              err_len,
    output logic              done,
    output logic [31:0]       bit_count
);

    localparam int CW = $clog2(ACCW + 1);

    state_e          state, state_n;
    logic [ACCW-1:0] acc, acc_n;
    logic [CW-1:0]   acc_cnt, acc_cnt_n;
    logic            restart;

    tbl_entry_t      wr_ent, rd_ent;
    logic            len_ok, accept;
    logic [ACCW-1:0] code_ext, code_al;

    assign wr_ent = '{len: tbl_len, code: CODE_W'(tbl_code)};

    huffman_code_table u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (tbl_we && !busy),
        .waddr (tbl_addr),
        .wdata (wr_ent),
        .raddr (sym_data),
        .rdata (rd_ent)
    );

    assign len_ok = (rd_ent.len != 5'd0) && (rd_ent.len <= 5'(MAXLEN));
    assign accept = (state == S_RUN) && sym_valid && (acc_cnt < CW'(8));

    // Mask to len bits, then left-align the code directly below the bits already held.
    assign code_ext = ACCW'(rd_ent.code) & ((ACCW'(1) << rd_ent.len) - ACCW'(1));
    assign code_al  = code_ext << (CW'(ACCW) - acc_cnt - CW'(rd_ent.len));

    assign out_data = acc[ACCW-1 -: 8];
    assign busy     = (state != S_RUN) || (acc_cnt != '0);

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        acc_cnt_n = acc_cnt;
        sym_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state)
            S_RUN: begin
                sym_ready = (acc_cnt < CW'(8));
                out_valid = (acc_cnt >= CW'(8));
                if (accept) begin
                    if (len_ok) begin
                        acc_n     = acc | code_al;
                        acc_cnt_n = acc_cnt + CW'(rd_ent.len);
                    end
                    if (sym_last) state_n = S_FLUSH;
                end else if (out_valid && out_ready) begin
                    acc_n     = acc << 8;
                    acc_cnt_n = acc_cnt - CW'(8);
                end
            end
            S_FLUSH: begin
                out_valid = (acc_cnt != '0);
                out_last  = out_valid && (acc_cnt <= CW'(8));
                if (acc_cnt == '0) begin
                    state_n = S_DONE;
                end else if (out_ready) begin
                    acc_n = acc << 8;
                    if (acc_cnt <= CW'(8)) begin
                        acc_cnt_n = '0;
                        state_n   = S_DONE;
                    end else begin
                        acc_cnt_n = acc_cnt - CW'(8);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_RUN;
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            acc       <= '0;
            acc_cnt   <= '0;
            err_len   <= 1'b0;
            bit_count <= '0;
            restart   <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            acc_cnt <= acc_cnt_n;
            if (accept && !len_ok) err_len <= 1'b1;
            // bit_count survives the end of a stream and restarts on the next accept.
            if (accept) begin
                bit_count <= (restart ? 32'd0 : bit_count) + (len_ok ? 32'(rd_ent.len) : 32'd0);
                restart   <= 1'b0;
            end else if (state == S_DONE) begin
                restart   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder: table A=0/1, B=10/2, C=11/2, hand-computed byte streams.
module tb_huffman_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sym_valid = 1'b0, sym_last = 1'b0, sym_ready;
    logic [7:0]  sym_data = '0;
    logic        out_valid, out_last, out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        tbl_we = 1'b0;
    logic [7:0]  tbl_addr = '0;
    logic [15:0] tbl_code = '0;
    logic [4:0]  tbl_len = '0;
    logic        busy, err_len, done;
    logic [31:0] bit_count;

    int          n_chk = 0, n_fail = 0, done_cnt = 0, d0;
    logic [8:0]  q[$];

    always #5 clk = ~clk;

    huffman_encoder #(.MAXLEN(16), .ACCW(24)) dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last), .sym_ready(sym_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
        .busy(busy), .err_len(err_len), .done(done), .bit_count(bit_count)
    );

    // Captures every byte that completes a handshake on the following rising edge.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (out_valid && out_ready) q.push_back({out_last, out_data});
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tbl_wr(input logic [7:0] a, input logic [15:0] c, input logic [4:0] l);
        tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int t = 0;
        sym_valid = 1'b1; sym_data = d; sym_last = last;
        while (!sym_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 32'(sym_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0; sym_last = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        for (int t = 0; t < 60; t++) begin
            if (done_cnt > base) break;
            @(negedge clk);
        end
        check(tag, 32'(done_cnt), 32'(base + 1));
    endtask

    task automatic load_abc();
        tbl_wr(8'h41, 16'h0000, 5'd1);
        tbl_wr(8'h42, 16'h0002, 5'd2);
        tbl_wr(8'h43, 16'h0003, 5'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_sym_ready", 32'(sym_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_bit_count", bit_count,      32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: "ABC" -> 0 10 11 -> 0x58 last
        load_abc();
        out_ready = 1'b1;
        q.delete(); d0 = done_cnt;
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b1);
        wait_done(d0, "t1_done");
        check("t1_nbytes", 32'(q.size()), 32'd1);
        check("t1_byte0",  32'(q[0]),     32'h158);
        check("t1_bits",   bit_count,     32'd5);
        check("t1_busy",   32'(busy),     32'd0);

        // 2: 8x B with sink stalled for the first byte
        out_ready = 1'b0;
        q.delete(); d0 = done_cnt;
        repeat (4) send(8'h42, 1'b0);
        check("t2_valid",     32'(out_valid), 32'd1);
        check("t2_data",      32'(out_data),  32'hAA);
        check("t2_sym_ready", 32'(sym_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_hold_data",  32'(out_data),  32'hAA);
            check("t2_hold_ready", 32'(sym_ready), 32'd0);
        end
        out_ready = 1'b1;
        repeat (3) send(8'h42, 1'b0);
        send(8'h42, 1'b1);
        wait_done(d0, "t2_done");
        check("t2_nbytes", 32'(q.size()), 32'd2);
        check("t2_byte0",  32'(q[0]),     32'h0AA);
        check("t2_byte1",  32'(q[1]),     32'h1AA);
        check("t2_bits",   bit_count,     32'd16);

        // 3: 16-bit code crossing byte boundaries
        tbl_wr(8'hFF, 16'hFFFF, 5'd16);
        q.delete(); d0 = done_cnt;
        send(8'h41, 1'b0); send(8'hFF, 1'b1);
        wait_done(d0, "t3_done");
        check("t3_nbytes", 32'(q.size()), 32'd3);
        check("t3_byte0",  32'(q[0]),     32'h07F);
        check("t3_byte1",  32'(q[1]),     32'h0FF);
        check("t3_byte2",  32'(q[2]),     32'h180);
        check("t3_bits",   bit_count,     32'd17);

        // 4: unmapped symbol, empty stream
        q.delete(); d0 = done_cnt;
        send(8'h00, 1'b1);
        wait_done(d0, "t4_done");
        check("t4_err",    32'(err_len),  32'd1);
        check("t4_nbytes", 32'(q.size()), 32'd0);
        check("t4_bits",   bit_count,     32'd0);

        // 5: reset while a flush byte is pending
        out_ready = 1'b0;
        q.delete();
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b1);
        @(negedge clk);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_last",  32'(out_last),  32'd1);
        check("t5_pre_data",  32'(out_data),  32'h58);
        rst = 1'b0;
        #1;
        check("t5_valid",     32'(out_valid), 32'd0);
        check("t5_data",      32'(out_data),  32'd0);
        check("t5_last",      32'(out_last),  32'd0);
        check("t5_sym_ready", 32'(sym_ready), 32'd1);
        check("t5_err",       32'(err_len),   32'd0);
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_bits",      bit_count,      32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        q.delete(); d0 = done_cnt;
        send(8'h42, 1'b1);
        wait_done(d0, "t5_done");
        check("t5_tbl_cleared", 32'(err_len),  32'd1);
        check("t5_nbytes",      32'(q.size()), 32'd0);

        // 6: table write while busy is dropped
        load_abc();
        q.delete(); d0 = done_cnt;
        send(8'h41, 1'b0);
        check("t6_busy", 32'(busy), 32'd1);
        tbl_wr(8'h43, 16'h0000, 5'd2);
        send(8'h43, 1'b1);
        wait_done(d0, "t6_done");
        check("t6_nbytes", 32'(q.size()), 32'd1);
        check("t6_byte0",  32'(q[0]),     32'h160);
        check("t6_bits",   bit_count,     32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
